save_wr_engine: RTL and testbench
=================================

// Module: save_wr_engine
// PURPOSE
//  Execution back end of the SAVE instruction: consumes start + latched reg_wr_* fields from the save parser,
//  reads bank words and writes them to DDR as one burst per line, then pulses wr_done back to the parser.
//  Sits between the save parser, the on-chip bank read port and the DDR write master.
// PARAMETERS
//  BID_W 6 bank id width | ADDR_W 12 bank addr/step width | OFFSET_W 4 bank offset width
//  LINE_SIZE_W 12 words per line | ALL_SIZE_W 16 total words, DDR step | DDR_ADDR_W 32 DDR word address
//  DATA_W 128 bank/DDR word width
// PORTS
//  clk            in  1            clock
//  rst            in  1            async active-high reset
//  start          in  1            1-cycle trigger; sample all reg_wr_* this cycle
//  zero_ddr_step  in  1            1: lines are contiguous in DDR
//  reg_wr_bank_id/addr/step/offset in BID_W/ADDR_W/ADDR_W/OFFSET_W   bank source descriptor
//  reg_wr_line_size in LINE_SIZE_W | reg_wr_total_size, reg_wr_ddr_step in ALL_SIZE_W | reg_wr_ddr_addr in DDR_ADDR_W
//  wr_done        out 1            1-cycle pulse: all bursts acknowledged
//  bank_rd_en     out 1            bank read strobe; data returns exactly 1 cycle later
//  bank_rd_id/addr/offset out BID_W/ADDR_W/OFFSET_W
//  bank_rd_data   in  DATA_W
//  ddr_cmd_valid  out 1 | ddr_cmd_ready in 1 | ddr_cmd_addr out DDR_ADDR_W | ddr_cmd_len out LINE_SIZE_W (words)
//  ddr_wdata_valid out 1 | ddr_wdata_ready in 1 | ddr_wdata out DATA_W | ddr_wdata_last out 1
//  ddr_resp       in  1            1-cycle pulse per completed burst
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0. Reset mid-operation aborts immediately, no wr_done.
//  - start latches descriptor into working regs; start while not IDLE is ignored.
//  - States: IDLE -> CMD (start) -> DATA (cmd accepted) -> CMD (line done, words remain)
//    | WRESP (line done, none remain) -> DONE (resp_cnt == lines issued) -> IDLE. DONE lasts 1 cycle = wr_done.
//  - Line i: len = min(line_size, remaining); bank base = bank_addr + i*bank_step (mod 2^ADDR_W);
//    DDR base = zero_ddr_step ? prev_base + prev_len : ddr_addr + i*ddr_step (zero-extended, mod 2^DDR_ADDR_W).
//  - CMD: ddr_cmd_valid held with stable addr/len until ddr_cmd_ready; valid must not drop before ready.
//  - DATA: word j read at bank base + j, bank_rd_id/offset = latched id/offset. Reads feed a 2-entry skid FIFO;
//    bank_rd_en only when (fifo occupancy + read in flight) < 2. FIFO head drives ddr_wdata;
//    ddr_wdata_last on final word of line. Full throughput 1 word/cycle when ddr_wdata_ready stays 1.
//  - ddr_resp counted in any state after start (may arrive during CMD/DATA of later lines); same-cycle resp
//    and cmd issue both counted.
//  - total_size == 0 or line_size == 0: no bank/DDR traffic; IDLE -> DONE, wr_done 2 cycles after start.
//  - remaining counter ALL_SIZE_W wide; line counter ALL_SIZE_W wide; no overflow beyond 2^16 words.
// STRUCTURE
//  - Shared package save_pkg: state encodings (ST_IDLE/CMD/DATA/WRESP/DONE), default widths.
//  - One sub-module: save_skid_fifo (2-deep, DATA_W, valid/ready both sides, count out).
// TESTING
//  1. total=8, line=4, bank_addr=0x10, step=0x20, ddr_addr=0x1000, ddr_step=0x100, ready=1 ->
//     cmds (0x1000,4),(0x1100,4); reads 0x10-0x13, 0x30-0x33; wr_done 1 cycle after 2nd ddr_resp.
//  2. total=10, line=4, zero_ddr_step=1, ddr_addr=0x2000 -> cmds (0x2000,4),(0x2004,4),(0x2008,2); last on words 4,8,10.
//  3. ddr_wdata_ready toggling 1/0 every cycle, line=6 -> no word lost/duplicated, bank_rd_en never with 2 in FIFO.
//  4. ddr_cmd_ready delayed 5 cycles; ddr_resp for line 0 during line 1 data -> addr/len stable, wr_done only after both resps.
//  5. total=0 -> no cmd/rd activity, wr_done exactly 2 cycles after start; second start during DATA ignored.
//  6. rst asserted mid-DATA -> all outputs 0 same cycle (async); next start runs full transfer correctly.

Source files
------------

// File: rtl/save_pkg.sv
// Shared types and default widths for the SAVE write engine.
package save_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WRESP,
    ST_DONE
  } state_e;

  localparam int BID_W_D       = 6;
  localparam int ADDR_W_D      = 12;
  localparam int OFFSET_W_D    = 4;
  localparam int LINE_SIZE_W_D = 12;
  localparam int ALL_SIZE_W_D  = 16;
  localparam int DDR_ADDR_W_D  = 32;
  localparam int DATA_W_D      = 128;
endpackage

// File: rtl/save_skid_fifo.sv
// Two-entry FIFO between the bank read port and the DDR write-data channel.
module save_skid_fifo #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);
  logic [DATA_W-1:0] mem0_q, mem1_q;
  logic [1:0]        cnt_q;
  logic              push, pop, to_slot1;

  assign out_valid_o = (cnt_q != 2'd0);
  assign in_ready_o  = (cnt_q != 2'd2) || out_ready_i;
  assign out_data_o  = mem0_q;
  assign count_o     = cnt_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  // Entry 0 is always the head; a push lands behind whatever survives the pop.
  assign to_slot1    = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (pop) mem0_q <= mem1_q;
      if (push) begin
        if (to_slot1) mem1_q <= in_data_i;
        else          mem0_q <= in_data_i;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/save_wr_engine.sv
// SAVE back end: walks the latched descriptor line by line, streaming bank
// words into one DDR burst per line, and pulses wr_done once every burst is acked.
module save_wr_engine
  import save_pkg::*;
#(
  parameter int BID_W       = BID_W_D,
  parameter int ADDR_W      = ADDR_W_D,
  parameter int OFFSET_W    = OFFSET_W_D,
  parameter int LINE_SIZE_W = LINE_SIZE_W_D,
  parameter int ALL_SIZE_W  = ALL_SIZE_W_D,
  parameter int DDR_ADDR_W  = DDR_ADDR_W_D,
  parameter int DATA_W      = DATA_W_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   zero_ddr_step,
  input  logic [BID_W-1:0]       reg_wr_bank_id,
  input  logic [ADDR_W-1:0]      reg_wr_bank_addr,
  input  logic [ADDR_W-1:0]      reg_wr_bank_step,
  input  logic [OFFSET_W-1:0]    reg_wr_bank_offset,
  input  logic [LINE_SIZE_W-1:0] reg_wr_line_size,
  input  logic [ALL_SIZE_W-1:0]  reg_wr_total_size,
  input  logic [ALL_SIZE_W-1:0]  reg_wr_ddr_step,
  input  logic [DDR_ADDR_W-1:0]  reg_wr_ddr_addr,
  output logic                   wr_done,
  output logic                   bank_rd_en,
  output logic [BID_W-1:0]       bank_rd_id,
  output logic [ADDR_W-1:0]      bank_rd_addr,
  output logic [OFFSET_W-1:0]    bank_rd_offset,
  input  logic [DATA_W-1:0]      bank_rd_data,
  output logic                   ddr_cmd_valid,
  input  logic                   ddr_cmd_ready,
  output logic [DDR_ADDR_W-1:0]  ddr_cmd_addr,
  output logic [LINE_SIZE_W-1:0] ddr_cmd_len,
  output logic                   ddr_wdata_valid,
  input  logic                   ddr_wdata_ready,
  output logic [DATA_W-1:0]      ddr_wdata,
  output logic                   ddr_wdata_last,
  input  logic                   ddr_resp
);
  state_e                 state_q, state_d;
  logic [BID_W-1:0]       id_q;
  logic [OFFSET_W-1:0]    offset_q;
  logic                   zstep_q;
  logic [ADDR_W-1:0]      bank_step_q, bank_base_q;
  logic [LINE_SIZE_W-1:0] line_size_q, line_len_q, rd_idx_q, wr_idx_q, cur_len;
  logic [ALL_SIZE_W-1:0]  ddr_step_q, remaining_q, rem_after, lines_q, resp_cnt_q;
  logic [DDR_ADDR_W-1:0]  ddr_base_q;
  logic                   rd_inflight_q;
  logic [1:0]             fifo_cnt;
  logic [2:0]             occ;
  logic                   fifo_in_ready, cmd_fire, wr_fire, line_end, zero_job;

  assign cur_len   = (remaining_q < ALL_SIZE_W'(line_size_q)) ? LINE_SIZE_W'(remaining_q) : line_size_q;
  assign rem_after = remaining_q - ALL_SIZE_W'(line_len_q);
  assign zero_job  = (reg_wr_total_size == '0) || (reg_wr_line_size == '0);
  assign cmd_fire  = ddr_cmd_valid && ddr_cmd_ready;
  assign wr_fire   = ddr_wdata_valid && ddr_wdata_ready;
  assign line_end  = wr_fire && ddr_wdata_last;
  // Slots still claimed after this cycle's pop; keeps the FIFO from overflowing
  // while still allowing one read per cycle when the DDR side keeps up.
  assign occ       = {1'b0, fifo_cnt} - {2'b0, wr_fire} + {2'b0, rd_inflight_q};

  assign ddr_cmd_valid  = (state_q == ST_CMD);
  assign ddr_cmd_addr   = ddr_base_q;
  assign ddr_cmd_len    = (state_q == ST_CMD) ? cur_len : '0;
  assign bank_rd_en     = (state_q == ST_DATA) && (rd_idx_q != line_len_q) && (occ < 3'd2) && fifo_in_ready;
  assign bank_rd_id     = id_q;
  assign bank_rd_offset = offset_q;
  assign bank_rd_addr   = bank_base_q + ADDR_W'(rd_idx_q);
  assign ddr_wdata_last = ddr_wdata_valid && (wr_idx_q == line_len_q - LINE_SIZE_W'(1));
  assign wr_done        = (state_q == ST_DONE);

  save_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (rd_inflight_q),
    .in_ready_o (fifo_in_ready),
    .in_data_i  (bank_rd_data),
    .out_valid_o(ddr_wdata_valid),
    .out_ready_i(ddr_wdata_ready),
    .out_data_o (ddr_wdata),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = zero_job ? ST_WRESP : ST_CMD;
      ST_CMD:   if (ddr_cmd_ready) state_d = ST_DATA;
      ST_DATA:  if (line_end) state_d = (rem_after == '0) ? ST_WRESP : ST_CMD;
      ST_WRESP: if (resp_cnt_q + ALL_SIZE_W'(ddr_resp) == lines_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      id_q          <= '0;
      offset_q      <= '0;
      zstep_q       <= 1'b0;
      bank_step_q   <= '0;
      bank_base_q   <= '0;
      line_size_q   <= '0;
      line_len_q    <= '0;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      ddr_step_q    <= '0;
      ddr_base_q    <= '0;
      remaining_q   <= '0;
      lines_q       <= '0;
      resp_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_inflight_q <= bank_rd_en;
      if (state_q == ST_IDLE) begin
        if (start) begin
          id_q        <= reg_wr_bank_id;
          offset_q    <= reg_wr_bank_offset;
          zstep_q     <= zero_ddr_step;
          bank_step_q <= reg_wr_bank_step;
          bank_base_q <= reg_wr_bank_addr;
          line_size_q <= reg_wr_line_size;
          ddr_step_q  <= reg_wr_ddr_step;
          ddr_base_q  <= reg_wr_ddr_addr;
          remaining_q <= reg_wr_total_size;
          lines_q     <= '0;
          resp_cnt_q  <= '0;
        end
      end else if (ddr_resp) begin
        resp_cnt_q <= resp_cnt_q + 1'b1;
      end
      if (cmd_fire) begin
        line_len_q <= cur_len;
        rd_idx_q   <= '0;
        wr_idx_q   <= '0;
        lines_q    <= lines_q + 1'b1;
      end
      if (bank_rd_en) rd_idx_q <= rd_idx_q + 1'b1;
      if (wr_fire)    wr_idx_q <= wr_idx_q + 1'b1;
      if (line_end) begin
        remaining_q <= rem_after;
        bank_base_q <= bank_base_q + bank_step_q;
        ddr_base_q  <= zstep_q ? ddr_base_q + DDR_ADDR_W'(line_len_q)
                               : ddr_base_q + DDR_ADDR_W'(ddr_step_q);
      end
    end
  end
endmodule

// File: tb/tb_save_wr_engine.sv
// Bench for save_wr_engine: table of directed jobs, randomized jobs, reset abort
// and stray-start sequences, all scored against a line-list reference model.
module tb_save_wr_engine;
  logic         clk = 1'b0;
  logic         rst;
  logic         start, zero_ddr_step;
  logic [5:0]   reg_wr_bank_id;
  logic [11:0]  reg_wr_bank_addr, reg_wr_bank_step, reg_wr_line_size;
  logic [3:0]   reg_wr_bank_offset;
  logic [15:0]  reg_wr_total_size, reg_wr_ddr_step;
  logic [31:0]  reg_wr_ddr_addr;
  logic         wr_done, bank_rd_en, ddr_cmd_valid, ddr_cmd_ready;
  logic [5:0]   bank_rd_id;
  logic [11:0]  bank_rd_addr, ddr_cmd_len;
  logic [3:0]   bank_rd_offset;
  logic [127:0] bank_rd_data, ddr_wdata;
  logic [31:0]  ddr_cmd_addr;
  logic         ddr_wdata_valid, ddr_wdata_ready, ddr_wdata_last, ddr_resp;

  always #5 clk = ~clk;

  save_wr_engine dut (
    .clk(clk), .rst(rst), .start(start), .zero_ddr_step(zero_ddr_step),
    .reg_wr_bank_id(reg_wr_bank_id), .reg_wr_bank_addr(reg_wr_bank_addr),
    .reg_wr_bank_step(reg_wr_bank_step), .reg_wr_bank_offset(reg_wr_bank_offset),
    .reg_wr_line_size(reg_wr_line_size), .reg_wr_total_size(reg_wr_total_size),
    .reg_wr_ddr_step(reg_wr_ddr_step), .reg_wr_ddr_addr(reg_wr_ddr_addr),
    .wr_done(wr_done), .bank_rd_en(bank_rd_en), .bank_rd_id(bank_rd_id),
    .bank_rd_addr(bank_rd_addr), .bank_rd_offset(bank_rd_offset), .bank_rd_data(bank_rd_data),
    .ddr_cmd_valid(ddr_cmd_valid), .ddr_cmd_ready(ddr_cmd_ready), .ddr_cmd_addr(ddr_cmd_addr),
    .ddr_cmd_len(ddr_cmd_len), .ddr_wdata_valid(ddr_wdata_valid), .ddr_wdata_ready(ddr_wdata_ready),
    .ddr_wdata(ddr_wdata), .ddr_wdata_last(ddr_wdata_last), .ddr_resp(ddr_resp)
  );

  typedef struct {
    logic [15:0] total;
    logic [11:0] line;
    logic [11:0] baddr;
    logic [11:0] bstep;
    logic [5:0]  id;
    logic [3:0]  off;
    logic [31:0] daddr;
    logic [15:0] dstep;
    logic        z;
    int          mode;     // 0 ready, 1 wdata toggle, 2 cmd delay 5, 3 random
    int          rdly;     // cycles from last beat to ddr_resp
    int          exp_ncmd; // -1: no table expectation
    logic [43:0] exp_last; // {addr, len} of the final command
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int mode = 0, rdly = 1, cmd_wait = 0;
  bit tog = 0;
  int resp_q[$];
  int resp_cyc[$];
  bit rd_pend = 0;
  logic [127:0] rd_val;
  int viol, n_done, done_cyc, start_cyc;
  logic [5:0] cur_id;
  logic [3:0] cur_off;
  bit prev_pend = 0;
  logic [43:0] prev_cmd;
  logic [43:0]  exp_cmd[$], got_cmd[$];
  logic [11:0]  exp_rd[$],  got_rd[$];
  logic [128:0] exp_w[$],   got_w[$];

  function automatic logic [127:0] bank_word(logic [5:0] id, logic [11:0] a, logic [3:0] o);
    return {26'd0, id, 28'd0, o, 20'd0, a, 32'hC0DE_0000 ^ ({20'd0, a} * 32'd7)};
  endfunction

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: everything for a cycle is stable at the falling edge.
  always @(negedge clk) begin
    rd_pend = bank_rd_en;
    rd_val  = bank_word(bank_rd_id, bank_rd_addr, bank_rd_offset);
    if (!rst) begin
      if (prev_pend && (!ddr_cmd_valid || {ddr_cmd_addr, ddr_cmd_len} != prev_cmd)) viol++;
      prev_pend = ddr_cmd_valid && !ddr_cmd_ready;
      prev_cmd  = {ddr_cmd_addr, ddr_cmd_len};
      if (ddr_cmd_valid && ddr_cmd_ready) got_cmd.push_back({ddr_cmd_addr, ddr_cmd_len});
      if (bank_rd_en) begin
        int held;
        held = got_rd.size() - got_w.size() - int'(ddr_wdata_valid && ddr_wdata_ready);
        if (held >= 2) viol++;
        if (bank_rd_id != cur_id || bank_rd_offset != cur_off) viol++;
        got_rd.push_back(bank_rd_addr);
      end
      if (ddr_wdata_valid && ddr_wdata_ready) begin
        got_w.push_back({ddr_wdata_last, ddr_wdata});
        if (ddr_wdata_last) resp_q.push_back(cyc + rdly);
      end
      if (ddr_resp) resp_cyc.push_back(cyc);
      if (wr_done) begin n_done++; done_cyc = cyc; end
      if (start && start_cyc < 0) start_cyc = cyc;
    end else prev_pend = 0;
  end

  // Bank and DDR responders, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    bank_rd_data = rd_pend ? rd_val : {4{$urandom}};
    ddr_resp = 1'b0;
    if (resp_q.size() > 0 && resp_q[0] <= cyc) begin
      void'(resp_q.pop_front());
      ddr_resp = 1'b1;
    end
    cmd_wait = ddr_cmd_valid ? cmd_wait + 1 : 0;
    tog = !tog;
    case (mode)
      0: begin ddr_cmd_ready = 1'b1; ddr_wdata_ready = 1'b1; end
      1: begin ddr_cmd_ready = 1'b1; ddr_wdata_ready = tog; end
      2: begin ddr_cmd_ready = (cmd_wait > 5); ddr_wdata_ready = 1'b1; end
      default: begin ddr_cmd_ready = ($urandom % 3) != 0; ddr_wdata_ready = ($urandom % 4) != 0; end
    endcase
  end

  // Reference: the job as a list of lines, each a burst of consecutive bank words.
  task automatic build_model(input vec_t v);
    int rem, i, len;
    logic [31:0] dsum, d;
    logic [11:0] b;
    exp_cmd.delete(); exp_rd.delete(); exp_w.delete();
    rem = int'(v.total); i = 0; dsum = 0;
    while (v.line != 0 && rem > 0) begin
      len = (rem < int'(v.line)) ? rem : int'(v.line);
      b = v.baddr + 12'(i * int'(v.bstep));
      d = v.z ? v.daddr + dsum : v.daddr + 32'(i) * {16'd0, v.dstep};
      exp_cmd.push_back({d, 12'(len)});
      for (int j = 0; j < len; j++) begin
        exp_rd.push_back(b + 12'(j));
        exp_w.push_back({(j == len - 1), bank_word(v.id, b + 12'(j), v.off)});
      end
      dsum += 32'(len); rem -= len; i++;
    end
  endtask

  task automatic drive_desc(input vec_t v);
    zero_ddr_step = v.z; reg_wr_bank_id = v.id; reg_wr_bank_addr = v.baddr;
    reg_wr_bank_step = v.bstep; reg_wr_bank_offset = v.off; reg_wr_line_size = v.line;
    reg_wr_total_size = v.total; reg_wr_ddr_step = v.dstep; reg_wr_ddr_addr = v.daddr;
  endtask

  task automatic scramble_desc();
    zero_ddr_step = 1'($urandom); reg_wr_bank_id = 6'($urandom); reg_wr_bank_addr = 12'($urandom);
    reg_wr_bank_step = 12'($urandom); reg_wr_bank_offset = 4'($urandom); reg_wr_line_size = 12'($urandom);
    reg_wr_total_size = 16'($urandom); reg_wr_ddr_step = 16'($urandom); reg_wr_ddr_addr = $urandom;
  endtask

  task automatic begin_job(input vec_t v);
    got_cmd.delete(); got_rd.delete(); got_w.delete(); resp_cyc.delete();
    viol = 0; n_done = 0; start_cyc = -1;
    mode = v.mode; rdly = v.rdly; cur_id = v.id; cur_off = v.off;
    build_model(v);
    @(posedge clk); #2;
    drive_desc(v); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; scramble_desc();
  endtask

  task automatic run(input vec_t v, input bit glitch, input string tag);
    bit gdone = 0;
    int n;
    begin_job(v);
    for (int t = 0; t < 3000 && n_done == 0; t++) begin
      @(negedge clk);
      if (glitch && !gdone && bank_rd_en) begin
        @(posedge clk); #2; scramble_desc(); start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        gdone = 1;
      end
    end
    repeat (4) @(negedge clk);
    n = exp_cmd.size();
    chk({tag, " done_count"}, n_done, 1);
    if (n == 0) chk({tag, " done_latency"}, done_cyc - start_cyc, 2);
    else if (resp_cyc.size() >= n) chk({tag, " done_after_resp"}, done_cyc - resp_cyc[n-1], 1);
    else chk({tag, " resp_count"}, resp_cyc.size(), n);
    chk({tag, " ncmd"}, got_cmd.size(), n);
    for (int i = 0; i < n && i < got_cmd.size(); i++) chk({tag, " cmd"}, got_cmd[i], exp_cmd[i]);
    chk({tag, " nrd"}, got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) chk({tag, " rd_addr"}, got_rd[i], exp_rd[i]);
    chk({tag, " nwords"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) chk({tag, " wdata"}, got_w[i], exp_w[i]);
    chk({tag, " protocol_viol"}, viol, 0);
    if (v.exp_ncmd >= 0) begin
      chk({tag, " tbl_ncmd"}, got_cmd.size(), v.exp_ncmd);
      if (v.exp_ncmd > 0 && got_cmd.size() > 0) chk({tag, " tbl_lastcmd"}, got_cmd[got_cmd.size()-1], v.exp_last);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vec_t r;
    int t;
    vecs[0] = '{16'd8,  12'd4,  12'h010, 12'h020, 6'd3, 4'd5,  32'h1000, 16'h100, 1'b0, 0, 2, 2, {32'h1100, 12'd4}};
    vecs[1] = '{16'd10, 12'd4,  12'h040, 12'h008, 6'd1, 4'd2,  32'h2000, 16'h999, 1'b1, 0, 1, 3, {32'h2008, 12'd2}};
    vecs[2] = '{16'd12, 12'd6,  12'h000, 12'h006, 6'd7, 4'd1,  32'h3000, 16'h040, 1'b0, 1, 3, 2, {32'h3040, 12'd6}};
    vecs[3] = '{16'd8,  12'd4,  12'h100, 12'h004, 6'd2, 4'd3,  32'h4000, 16'h010, 1'b0, 2, 7, 2, {32'h4010, 12'd4}};
    vecs[4] = '{16'd0,  12'd4,  12'h100, 12'h004, 6'd2, 4'd3,  32'h4000, 16'h010, 1'b0, 0, 2, 0, 44'd0};
    vecs[5] = '{16'd5,  12'd0,  12'h100, 12'h004, 6'd2, 4'd3,  32'h4000, 16'h010, 1'b0, 0, 2, 0, 44'd0};
    vecs[6] = '{16'd6,  12'd3,  12'hFFE, 12'hFF0, 6'd9, 4'd15, 32'hFFFF_FFFE, 16'h4, 1'b0, 3, 4, 2, {32'h0000_0002, 12'd3}};
    vecs[7] = '{16'd3,  12'd16, 12'h200, 12'h001, 6'd4, 4'd7,  32'h5000, 16'h080, 1'b1, 0, 5, 1, {32'h5000, 12'd3}};

    rst = 1'b1; start = 1'b0; ddr_cmd_ready = 1'b0; ddr_wdata_ready = 1'b0; ddr_resp = 1'b0;
    bank_rd_data = '0; scramble_desc();
    repeat (3) @(negedge clk);
    chk("reset_state", {wr_done, bank_rd_en, ddr_cmd_valid, ddr_wdata_valid, ddr_wdata_last,
                        ddr_cmd_len, ddr_cmd_addr, bank_rd_addr, bank_rd_id, bank_rd_offset}, '0);
    @(posedge clk); #2 rst = 1'b0;

    for (int i = 0; i < 8; i++) run(vecs[i], 1'b0, $sformatf("tbl%0d", i));
    run(vecs[3], 1'b1, "stray_start");
    run(vecs[4], 1'b1, "zero_stray");

    // Abort mid-burst with reset, then rerun a full job.
    r = '{16'd16, 12'd8, 12'h300, 12'h040, 6'd5, 4'd9, 32'h6000, 16'h200, 1'b0, 0, 3, 2, {32'h6200, 12'd8}};
    begin_job(r);
    t = 0;
    while (!bank_rd_en && t < 100) begin @(negedge clk); t++; end
    chk("abort_reached_data", bank_rd_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", {wr_done, bank_rd_en, ddr_cmd_valid, ddr_wdata_valid, ddr_wdata_last,
                          ddr_cmd_len, ddr_cmd_addr, bank_rd_addr, bank_rd_id, bank_rd_offset}, '0);
    chk("abort_wdata", ddr_wdata, '0);
    resp_q.delete();
    @(posedge clk); #3 rst = 1'b0;
    n_done = 0;
    repeat (10) @(negedge clk);
    chk("abort_no_done", n_done, 0);
    run(r, 1'b0, "after_abort");

    for (int k = 0; k < 25; k++) begin
      r.total = 16'($urandom_range(0, 40));
      r.line  = ($urandom % 6 == 0) ? 12'd0 : 12'($urandom_range(1, 9));
      r.baddr = 12'($urandom); r.bstep = 12'($urandom);
      r.id = 6'($urandom); r.off = 4'($urandom);
      r.daddr = $urandom; r.dstep = 16'($urandom); r.z = 1'($urandom);
      r.mode = $urandom_range(0, 3); r.rdly = $urandom_range(1, 8);
      r.exp_ncmd = -1; r.exp_last = '0;
      run(r, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
